ioctl_upload_server: RTL and testbench

Serves core-side memory bytes to the HPS over the hps_io ioctl upload path, for example NVRAM or hiscore saves. It is the read-direction counterpart of the ROM download path. It sits between hps_io (ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din/ioctl_wait/ioctl_upload_req) and a req/ack read port into core RAM or SDRAM. It also tracks core writes to the save region and raises an upload request once writes have settled.

---
 rtl/ioctl_upload_pkg.sv | 28 ++
 rtl/ioctl_upload_server_settle.sv | 62 ++++++
 rtl/ioctl_upload_server.sv | 160 ++++++++++++++++
 tb/tb_ioctl_upload_server.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_upload_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_upload_pkg
//  Description : Shared state encoding, fixed data codes and helpers for the
//                ioctl upload server (core memory -> HPS read path).
//  Revision    : 1.0  initial release
// ============================================================================
package ioctl_upload_pkg;

    // Upload FSM state encoding
    typedef logic [1:0] upload_state_t;
    localparam upload_state_t S_IDLE  = 2'd0;
    localparam upload_state_t S_FETCH = 2'd1;
    localparam upload_state_t S_DRAIN = 2'd2;

    // Byte returned for addresses beyond the save region
    localparam logic [7:0] DIN_OOR     = 8'h00;
    // Byte returned when the memory never acknowledged
    localparam logic [7:0] DIN_TIMEOUT = 8'hFF;

    // True when a requested hps_io byte address falls inside the save region
    function automatic logic addr_in_region(input logic [26:0] addr,
                                            input int unsigned size);
        return 32'(addr) < 32'(size);
    endfunction

endpackage : ioctl_upload_pkg
`default_nettype wire

// File: rtl/ioctl_upload_server_settle.sv
`default_nettype none
// ============================================================================
//  Module      : upload_settle_timer
//  Description : Tracks core writes into the save region and emits a single
//                upload request pulse once writes have been quiet for
//                SETTLE_CYCLES cycles outside of an active upload.
//  Revision    : 1.0  initial release
// ============================================================================
module upload_settle_timer #(
    parameter int SETTLE_CYCLES = 2**20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_dirty,
    input  logic i_upload,
    input  logic i_index_match,
    output logic o_req
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic          r_dirty;
    logic [CW-1:0] r_cnt;
    logic          r_upload_d;
    logic          w_rise;
    logic          w_fire;

    // A fresh upload of our index means the HPS is already saving: forget dirt
    assign w_rise = i_upload & ~r_upload_d & i_index_match;
    // Fire on the last quiet cycle; a simultaneous write restarts the wait
    assign w_fire = r_dirty & ~i_upload & ~i_dirty & (r_cnt == C_CNT_LAST);
    assign o_req  = w_fire;

    // Dirty flag and saturating quiet-time counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dirty    <= 1'b0;
            r_cnt      <= '0;
            r_upload_d <= 1'b0;
        end else begin
            r_upload_d <= i_upload;
            if (i_dirty) begin
                r_dirty <= 1'b1;
                r_cnt   <= '0;
            end else if (w_rise) begin
                r_dirty <= 1'b0;
                r_cnt   <= '0;
            end else if (w_fire) begin
                r_dirty <= 1'b0;
                r_cnt   <= '0;
            end else if (i_upload) begin
                // quiet time only counts once the upload has ended
                r_cnt <= '0;
            end else if (r_dirty && (r_cnt != C_CNT_LAST)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : upload_settle_timer
`default_nettype wire

// File: rtl/ioctl_upload_server.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_upload_server
//  Description : Answers hps_io ioctl upload reads for one file index by
//                fetching bytes through a req/ack port into core memory, and
//                requests an upload after core writes to the region settle.
//  Revision    : 1.0  initial release
// ============================================================================
module ioctl_upload_server #(
    parameter logic [15:0] UPLOAD_INDEX  = 16'd4,
    parameter int          AW            = 16,
    parameter int          SIZE          = 1024,
    parameter int          SETTLE_CYCLES = 2**20,
    parameter int          TIMEOUT       = 255
) (
    input  logic          i_EMU_MCLK,
    input  logic          i_EMU_INITRST_n,
    input  logic          ioctl_upload,
    input  logic [15:0]   ioctl_index,
    input  logic [26:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          ioctl_upload_req,
    output logic [AW-1:0] o_MEM_ADDR,
    output logic          o_MEM_REQ,
    input  logic          i_MEM_ACK,
    input  logic [7:0]    i_MEM_DATA,
    input  logic          i_DIRTY,
    output logic          o_BUSY,
    output logic          o_ERR
);

    import ioctl_upload_pkg::*;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    upload_state_t r_state;
    logic [7:0]    r_tmo;
    logic          r_abort;
    logic          r_pend;
    logic [26:0]   r_pend_addr;

    logic          w_idx_match;
    logic          w_hit;
    logic          w_in_range;
    logic          w_hit_inr;
    logic          w_pend_inr;
    logic          w_start;
    logic          w_oor;
    logic [26:0]   w_start_addr;
    logic          w_wait;

    assign w_idx_match = (ioctl_index == UPLOAD_INDEX);
    assign w_hit       = ioctl_upload & w_idx_match & ioctl_rd;
    assign w_in_range  = addr_in_region(ioctl_addr, SIZE);
    assign w_hit_inr   = w_hit & w_in_range;
    assign w_pend_inr  = addr_in_region(r_pend_addr, SIZE);

    // A read queued during DRAIN takes priority over any new strobe in IDLE
    assign w_start_addr = r_pend ? r_pend_addr : ioctl_addr;
    assign w_start      = (r_state == S_IDLE) & (r_pend ? w_pend_inr : w_hit_inr);
    assign w_oor        = (r_state == S_IDLE) & (r_pend ? ~w_pend_inr : (w_hit & ~w_in_range));

    // Stall hps_io while a byte is being fetched or a queued read is pending
    always_comb begin
        w_wait = 1'b0;
        case (r_state)
            S_IDLE:  w_wait = r_pend | w_hit_inr;
            S_FETCH: w_wait = ioctl_upload & ~r_abort;
            S_DRAIN: w_wait = r_pend | w_hit_inr;
            default: w_wait = 1'b0;
        endcase
    end

    assign ioctl_wait = w_wait;
    assign o_BUSY     = (r_state != S_IDLE);

    // Fetch FSM: issue memory read, wait for ack or timeout, absorb late acks
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_state     <= S_IDLE;
            r_tmo       <= 8'd0;
            r_abort     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_addr <= 27'd0;
            ioctl_din   <= 8'd0;
            o_MEM_ADDR  <= '0;
            o_MEM_REQ   <= 1'b0;
            o_ERR       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pend <= 1'b0;
                    if (w_start) begin
                        o_MEM_ADDR <= w_start_addr[AW-1:0];
                        o_MEM_REQ  <= 1'b1;
                        r_tmo      <= 8'd0;
                        r_abort    <= 1'b0;
                        r_state    <= S_FETCH;
                    end else if (w_oor) begin
                        ioctl_din <= DIN_OOR;
                    end
                end
                S_FETCH: begin
                    // once the upload is gone the result is no longer wanted,
                    // but the request stays up so req/ack stays paired
                    if (!ioctl_upload) begin
                        r_abort <= 1'b1;
                    end
                    if (i_MEM_ACK) begin
                        o_MEM_REQ <= 1'b0;
                        r_state   <= S_IDLE;
                        if (ioctl_upload && !r_abort) begin
                            ioctl_din <= i_MEM_DATA;
                        end
                    end else if (r_tmo == C_TMO_LAST) begin
                        ioctl_din <= DIN_TIMEOUT;
                        o_ERR     <= 1'b1;
                        o_MEM_REQ <= 1'b0;
                        r_tmo     <= 8'd0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_hit && !r_pend) begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= ioctl_addr;
                    end
                    if (i_MEM_ACK || (r_tmo == C_TMO_LAST)) begin
                        r_tmo   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                default: begin
                    o_MEM_REQ <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Write-settle tracking and upload request generation
    upload_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk         (i_EMU_MCLK),
        .i_rst_n       (i_EMU_INITRST_n),
        .i_dirty       (i_DIRTY),
        .i_upload      (ioctl_upload),
        .i_index_match (w_idx_match),
        .o_req         (ioctl_upload_req)
    );

endmodule : ioctl_upload_server
`default_nettype wire

// File: tb/tb_ioctl_upload_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_upload_server
//  Description : Self-checking bench for ioctl_upload_server.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ioctl_upload_server;

    localparam int SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upload = 1'b0;
    logic [15:0] idx = 16'd0;
    logic [26:0] addr = 27'd0;
    logic        rd = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  mdata = 8'd0;
    logic        dirty = 1'b0;
    logic [7:0]  din;
    logic        wt;
    logic        upreq;
    logic [15:0] maddr;
    logic        mreq;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0] mem [0:SIZE-1];

    ioctl_upload_server #(
        .UPLOAD_INDEX  (16'd4),
        .AW            (16),
        .SIZE          (SIZE),
        .SETTLE_CYCLES (16),
        .TIMEOUT       (255)
    ) dut (
        .i_EMU_MCLK       (clk),
        .i_EMU_INITRST_n  (rst_n),
        .ioctl_upload     (upload),
        .ioctl_index      (idx),
        .ioctl_addr       (addr),
        .ioctl_rd         (rd),
        .ioctl_din        (din),
        .ioctl_wait       (wt),
        .ioctl_upload_req (upreq),
        .o_MEM_ADDR       (maddr),
        .o_MEM_REQ        (mreq),
        .i_MEM_ACK        (ack),
        .i_MEM_DATA       (mdata),
        .i_DIRTY          (dirty),
        .o_BUSY           (busy),
        .o_ERR            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One hps_io read: strobe rd, act as memory (answer dly cycles after req
    // appears, dly<0 = never), count stalled cycles until ioctl_wait drops.
    task automatic do_read(input logic [15:0] i_idx, input logic [26:0] i_addr,
                           input int dly, output int wcnt, output logic reqseen,
                           output logic [15:0] seen_addr);
        int reqcnt;
        @(negedge clk);
        upload = 1'b1; idx = i_idx; addr = i_addr; rd = 1'b1; ack = 1'b0;
        #1;
        wcnt = wt ? 1 : 0;
        reqseen = 1'b0; seen_addr = 16'd0; reqcnt = 0;
        for (int c = 1; c < 600; c++) begin
            @(negedge clk);
            rd = 1'b0;
            if (mreq) begin
                reqseen = 1'b1;
                seen_addr = maddr;
            end
            ack = mreq && (dly >= 0) && (reqcnt == dly);
            mdata = mem[maddr[9:0]];
            if (mreq) reqcnt++;
            #1;
            if (wt) wcnt++;
            else break;
        end
        ack = 1'b0;
    endtask

    typedef struct {
        logic [15:0] idx;
        logic [26:0] addr;
        int          dly;
        logic [7:0]  data;
        int          exp_wait;
        logic        exp_req;
        logic [7:0]  exp_din;
    } vec_t;

    initial begin
        vec_t       vt[6];
        int         w;
        logic       rs;
        logic [15:0] sa;
        logic [7:0] model_din;
        int         npulse;
        int         pcyc;

        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_din", 32'(din), 32'h0);
        chk("rst_wait", 32'(wt), 32'h0);
        chk("rst_req", 32'(mreq), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_upreq", 32'(upreq), 32'h0);
        chk("rst_maddr", 32'(maddr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table: idx, addr, ack delay, data, stall cycles, req, din
        vt[0] = '{16'd4, 27'h010,     5, 8'hA5, 7, 1'b1, 8'hA5};
        vt[1] = '{16'd3, 27'h020,     2, 8'h11, 0, 1'b0, 8'hA5};
        vt[2] = '{16'd4, 27'd1024,    2, 8'h22, 0, 1'b0, 8'h00};
        vt[3] = '{16'd4, 27'd1023,    0, 8'h3C, 2, 1'b1, 8'h3C};
        vt[4] = '{16'd4, 27'h000,     2, 8'h81, 4, 1'b1, 8'h81};
        vt[5] = '{16'd4, 27'h7FFFFFF, 0, 8'h00, 0, 1'b0, 8'h00};
        for (int i = 0; i < 6; i++) begin
            if (vt[i].addr < 27'(SIZE)) mem[vt[i].addr[9:0]] = vt[i].data;
            do_read(vt[i].idx, vt[i].addr, vt[i].dly, w, rs, sa);
            chk($sformatf("vec%0d_wait", i), 32'(w), 32'(vt[i].exp_wait));
            chk($sformatf("vec%0d_req", i), 32'(rs), 32'(vt[i].exp_req));
            chk($sformatf("vec%0d_din", i), 32'(din), 32'(vt[i].exp_din));
            if (vt[i].exp_req) chk($sformatf("vec%0d_maddr", i), 32'(sa), 32'(vt[i].addr[15:0]));
        end

        // timeout: no ack -> 0xFF, sticky error, late ack swallowed in DRAIN
        do_read(16'd4, 27'h040, -1, w, rs, sa);
        chk("tmo_wait", 32'(w), 32'd256);
        chk("tmo_din", 32'(din), 32'hFF);
        chk("tmo_err", 32'(err), 32'h1);
        chk("tmo_req", 32'(mreq), 32'h0);
        chk("tmo_busy", 32'(busy), 32'h1);
        for (int c = 257; c < 300; c++) @(negedge clk);
        ack = 1'b1; mdata = 8'h5A;
        #1;
        chk("drain_busy", 32'(busy), 32'h1);
        chk("drain_wait", 32'(wt), 32'h0);
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("drain_exit", 32'(busy), 32'h0);
        chk("drain_din", 32'(din), 32'hFF);
        mem[10'h041] = 8'h6E;
        do_read(16'd4, 27'h041, 3, w, rs, sa);
        chk("post_tmo_wait", 32'(w), 32'd5);
        chk("post_tmo_din", 32'(din), 32'h6E);
        chk("err_sticky", 32'(err), 32'h1);

        // abort: upload drops while fetching, data from the ack is discarded
        @(negedge clk);
        upload = 1'b1; idx = 16'd4; addr = 27'h055; rd = 1'b1;
        #1;
        chk("abort_wait_rd", 32'(wt), 32'h1);
        @(negedge clk);
        rd = 1'b0;
        #1;
        chk("abort_req", 32'(mreq), 32'h1);
        @(negedge clk);
        upload = 1'b0;
        #1;
        chk("abort_wait", 32'(wt), 32'h0);
        chk("abort_req_held", 32'(mreq), 32'h1);
        @(negedge clk);
        ack = 1'b1; mdata = 8'h77;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_din", 32'(din), 32'h6E);
        chk("abort_req_off", 32'(mreq), 32'h0);
        model_din = 8'h6E;

        // dirty: two pulses 5 apart -> one request 16 cycles after the second
        npulse = 0; pcyc = -1;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            dirty = (c == 0) || (c == 5);
            #1;
            if (upreq) begin npulse++; pcyc = c; end
        end
        dirty = 1'b0;
        chk("dirty_npulse", 32'(npulse), 32'd1);
        chk("dirty_cycle", 32'(pcyc), 32'd21);

        // dirty during upload (also coincident with upload start): 16 after end
        npulse = 0; pcyc = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            upload = (c <= 9); idx = 16'd4;
            dirty = (c == 0);
            #1;
            if (upreq) begin npulse++; pcyc = c; end
        end
        dirty = 1'b0; upload = 1'b0;
        chk("upl_npulse", 32'(npulse), 32'd1);
        chk("upl_cycle", 32'(pcyc), 32'd25);

        // upload starting after a write clears the pending request
        npulse = 0;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            upload = (c >= 3) && (c <= 6);
            dirty = (c == 0);
            #1;
            if (upreq) npulse++;
        end
        dirty = 1'b0; upload = 1'b0;
        chk("clr_npulse", 32'(npulse), 32'd0);

        // randomized reads against a reference of the read rules
        for (int i = 0; i < 40; i++) begin
            logic [15:0] r_idx;
            logic [26:0] r_addr;
            int          r_dly;
            int          e_wait;
            logic        e_req;
            r_idx  = ($urandom_range(0, 3) == 0) ? 16'd3 : 16'd4;
            r_addr = ($urandom_range(0, 4) == 0) ? 27'(SIZE + $urandom_range(0, 200))
                                                 : 27'($urandom_range(0, SIZE - 1));
            r_dly  = $urandom_range(0, 7);
            e_wait = 0; e_req = 1'b0;
            if (r_idx == 16'd4) begin
                if (r_addr < 27'(SIZE)) begin
                    e_wait = r_dly + 2; e_req = 1'b1;
                    model_din = mem[r_addr[9:0]];
                end else begin
                    model_din = 8'h00;
                end
            end
            do_read(r_idx, r_addr, r_dly, w, rs, sa);
            chk($sformatf("rnd%0d_wait", i), 32'(w), 32'(e_wait));
            chk($sformatf("rnd%0d_req", i), 32'(rs), 32'(e_req));
            chk($sformatf("rnd%0d_din", i), 32'(din), 32'(model_din));
            if (e_req) chk($sformatf("rnd%0d_maddr", i), 32'(sa), 32'(r_addr[15:0]));
        end

        // asynchronous reset while a fetch is outstanding
        @(negedge clk);
        upload = 1'b1; idx = 16'd4; addr = 27'h010; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_req", 32'(mreq), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mreq), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_wait", 32'(wt), 32'h0);
        chk("arst_din", 32'(din), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_maddr", 32'(maddr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_req", 32'(mreq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_ioctl_upload_server
`default_nettype wire
